// File: rtl/muldiv_pkg.sv
// Shared opcode and state encodings for the iterative RV32M multiply/divide unit,
// plus small decode predicates used by the datapath and the sign-fix logic.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitude conversion on the way in,
// result negation and high/low/quotient/remainder select on the way out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  muldiv_op_e              op_i,
    input  logic [DATA_WIDTH-1:0]   src_a_i,
    input  logic [DATA_WIDTH-1:0]   src_b_i,
    output logic                    neg_a_o,
    output logic                    neg_b_o,
    output logic [DATA_WIDTH-1:0]   mag_a_o,
    output logic [DATA_WIDTH-1:0]   mag_b_o,
    input  muldiv_op_e              res_op_i,
    input  logic                    res_neg_a_i,
    input  logic                    res_neg_b_i,
    input  logic [DATA_WIDTH-1:0]   hi_i,
    input  logic [DATA_WIDTH-1:0]   lo_i,
    output logic [DATA_WIDTH-1:0]   result_o
);

    logic                      neg_a;
    logic                      neg_b;
    logic                      neg_res;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic [2*DATA_WIDTH-1:0]   prod_fix;
    logic [DATA_WIDTH-1:0]     quo_fix;
    logic [DATA_WIDTH-1:0]     rem_fix;

    always_comb begin
        neg_a   = is_signed_a(op_i) && src_a_i[DATA_WIDTH-1];
        neg_b   = is_signed_b(op_i) && src_b_i[DATA_WIDTH-1];
        neg_a_o = neg_a;
        neg_b_o = neg_b;
        mag_a_o = neg_a ? ({DATA_WIDTH{1'b0}} - src_a_i) : src_a_i;
        mag_b_o = neg_b ? ({DATA_WIDTH{1'b0}} - src_b_i) : src_b_i;
    end

    // Quotient and product take the xor of the signs; the remainder follows the dividend.
    always_comb begin
        neg_res  = res_neg_a_i ^ res_neg_b_i;
        prod     = {hi_i, lo_i};
        prod_fix = neg_res ? ({(2*DATA_WIDTH){1'b0}} - prod) : prod;
        quo_fix  = neg_res ? ({DATA_WIDTH{1'b0}} - lo_i) : lo_i;
        rem_fix  = res_neg_a_i ? ({DATA_WIDTH{1'b0}} - hi_i) : hi_i;
        result_o = rem_fix;
        case (res_op_i)
            OP_MUL:                       result_o = prod_fix[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:              result_o = quo_fix;
            default:                      result_o = rem_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, with a single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int                    CW      = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]         LAST    = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    muldiv_state_e             state_q, state_d;
    muldiv_op_e                op_q, op_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      neg_a_q, neg_a_d;
    logic                      neg_b_q, neg_b_d;
    logic [DATA_WIDTH-1:0]     hi_q, hi_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic [DATA_WIDTH-1:0]     b_q, b_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;

    muldiv_op_e                op_in;
    logic                      in_neg_a, in_neg_b;
    logic [DATA_WIDTH-1:0]     mag_a, mag_b;
    logic [DATA_WIDTH-1:0]     fix_result;
    logic                      fast_hit;
    logic [DATA_WIDTH-1:0]     fast_result;
    logic [DATA_WIDTH:0]       mul_sum;
    logic [DATA_WIDTH:0]       div_shift;
    logic [DATA_WIDTH:0]       div_diff;
    logic                      div_ge;
    logic [DATA_WIDTH-1:0]     iter_hi, iter_lo;

    assign op_in = muldiv_op_e'(Operation);

    muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
        .op_i        (op_in),
        .src_a_i     (SrcA),
        .src_b_i     (SrcB),
        .neg_a_o     (in_neg_a),
        .neg_b_o     (in_neg_b),
        .mag_a_o     (mag_a),
        .mag_b_o     (mag_b),
        .res_op_i    (op_q),
        .res_neg_a_i (neg_a_q),
        .res_neg_b_i (neg_b_q),
        .hi_i        (iter_hi),
        .lo_i        (iter_lo),
        .result_o    (fix_result)
    );

    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
        if (is_div(op_in)) begin
            if (SrcB == '0) begin
                fast_hit    = 1'b1;
                fast_result = is_rem(op_in) ? SrcA : {DATA_WIDTH{1'b1}};
            end else if (is_signed_a(op_in) && SrcA == MIN_INT && SrcB == {DATA_WIDTH{1'b1}}) begin
                fast_hit    = 1'b1;
                fast_result = is_rem(op_in) ? {DATA_WIDTH{1'b0}} : MIN_INT;
            end
        end
    end

    // hi:lo is the product accumulator for multiply, remainder:quotient for divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(DATA_WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift - {1'b0, b_q};
        if (is_div(op_q)) begin
            iter_hi = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
            iter_lo = {lo_q[DATA_WIDTH-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[DATA_WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    count_d = '0;
                    hi_d    = '0;
                    lo_d    = is_div(op_in) ? mag_a : mag_b;
                    b_d     = is_div(op_in) ? mag_b : mag_a;
                    if (fast_hit) begin
                        result_d = fast_result;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                hi_d    = iter_hi;
                lo_d    = iter_lo;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    result_d = fix_result;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign Result = result_q;

endmodule
